// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with sequential/jump/branch/call/return selection,
// a circular return-address stack, stall hold and sticky error flags.
module pc_sequencer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP      = 4,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic             redirect,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic             sel_err
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] SelSeq    = 3'b000;
    localparam logic [2:0] SelJump   = 3'b001;
    localparam logic [2:0] SelBranch = 3'b010;
    localparam logic [2:0] SelCall   = 3'b011;
    localparam logic [2:0] SelRet    = 3'b100;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_pc, br_pc, top;
    logic             redirect_q, redirect_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic [PW-1:0]    ptr_q, ptr_d, ptr_dec;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    assign seq_pc    = pc_q + WIDTH'(STEP);
    assign br_pc     = seq_pc + offset;
    assign ptr_dec   = ptr_q - PW'(1);
    assign top       = ras_mem[ptr_dec];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        if (!stall) begin
            case (sel)
                SelSeq: pc_d = seq_pc;
                SelJump: begin
                    pc_d       = target;
                    redirect_d = 1'b1;
                end
                SelBranch: begin
                    pc_d       = br_pc;
                    redirect_d = 1'b1;
                end
                SelCall: begin
                    pc_d       = target;
                    redirect_d = 1'b1;
                    push       = 1'b1;
                    ptr_d      = ptr_q + PW'(1);
                    // When full the pointer sits on the oldest entry, so the push overwrites it.
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SelRet: begin
                    if (!ras_empty) begin
                        pc_d       = top;
                        redirect_d = 1'b1;
                        ptr_d      = ptr_dec;
                        cnt_d      = cnt_q - CW'(1);
                    end else begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= WIDTH'(RESET_PC);
            redirect_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stack storage is not reset; only the pointer and count are.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            ras_mem[ptr_q] <= seq_pc;
        end
    end

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign ras_ovf  = ovf_q;
    assign ras_unf  = unf_q;
    assign sel_err  = err_q;

endmodule
